// File: rtl/lsu_handshake_pkg.sv
// Shared encodings for the load/store unit.
// Holds the pipeline op codes, access-type codes, FSM state encoding and the
// alignment rule shared by the FSM.
package lsu_handshake_pkg;

   typedef enum logic [1:0] {
      OP_LOAD    = 2'b00,
      OP_STORE   = 2'b01,
      OP_NOP     = 2'b10,
      OP_NOP_ALT = 2'b11
   } lsu_op_e;

   // Codes 101..111 are not listed; they behave as a word access.
   typedef enum logic [2:0] {
      TY_WORD   = 3'b000,
      TY_HALF_U = 3'b001,
      TY_HALF_S = 3'b010,
      TY_BYTE_U = 3'b011,
      TY_BYTE_S = 3'b100
   } lsu_type_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUS  = 2'b01,
      ST_RESP = 2'b10
   } lsu_state_e;

   // Half accesses need an even address, word accesses a multiple of four.
   function automatic logic is_misaligned(input logic [2:0] ty, input logic [1:0] lane);
      case (ty)
         TY_HALF_U, TY_HALF_S: return lane[0];
         TY_BYTE_U, TY_BYTE_S: return 1'b0;
         default:              return lane != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit (purely combinational).
// Ports:
//   ty       access type (lsu_type_e code, 101..111 treated as word)
//   lane     byte offset within the word (addr[1:0])
//   wdata    raw store data from the pipeline
//   rdata    raw word read from the bus
//   st_wdata store data replicated onto every lane the access may hit
//   st_be    byte enables for a store
//   ld_data  load data shifted down to bit 0 and zero/sign extended
module lsu_align
   import lsu_handshake_pkg::*;
(
   input  logic [2:0]  ty,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [31:0] st_wdata,
   output logic [3:0]  st_be,
   output logic [31:0] ld_data
);

   logic [31:0] rshift;

   always_comb begin
      rshift   = rdata >> {lane, 3'b000};
      st_wdata = wdata;
      st_be    = 4'b1111;
      ld_data  = rshift;
      case (ty)
         TY_HALF_U: begin
            st_wdata = {2{wdata[15:0]}};
            st_be    = 4'b0011 << lane;
            ld_data  = {16'h0000, rshift[15:0]};
         end
         TY_HALF_S: begin
            st_wdata = {2{wdata[15:0]}};
            st_be    = 4'b0011 << lane;
            ld_data  = {{16{rshift[15]}}, rshift[15:0]};
         end
         TY_BYTE_U: begin
            st_wdata = {4{wdata[7:0]}};
            st_be    = 4'b0001 << lane;
            ld_data  = {24'h000000, rshift[7:0]};
         end
         TY_BYTE_S: begin
            st_wdata = {4{wdata[7:0]}};
            st_be    = 4'b0001 << lane;
            ld_data  = {{24{rshift[7]}}, rshift[7:0]};
         end
         default: begin
            st_wdata = wdata;
            st_be    = 4'b1111;
            ld_data  = rshift;
         end
      endcase
   end

endmodule

// File: rtl/lsu_handshake.sv
// Registered load/store unit between the execute stage and the data RAM.
// Accepts one access at a time over a valid/ready handshake, runs it on a
// req/ack wait-state bus, and returns a one-cycle response for write-back.
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   halt              pipeline freeze (blocks accept, holds the response)
//   req_*             access from the pipeline (op, type, addr, wdata, rd)
//   mem_*             wait-state bus: req/read_wrn/addr/wdata/be out, ack/rdata in
//   rsp_*             completion pulse, write-back enable, rd and load data
//   stall             LSU busy, pipeline must hold
//   err_misalign      sticky: a misaligned access was rejected
//   err_timeout       sticky: a bus access was aborted for lack of ack
module lsu_handshake
   import lsu_handshake_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              halt,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [2:0]        req_type,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [4:0]        req_rd,
   output logic              mem_req,
   output logic              mem_read_wrn,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              rsp_valid,
   output logic              rsp_wb,
   output logic [4:0]        rsp_rd,
   output logic [31:0]       rsp_data,
   output logic              stall,
   output logic              err_misalign,
   output logic              err_timeout
);

   // Counter value on the last BUS cycle before the timeout fires.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   lsu_state_e        state_q, state_d;
   logic [1:0]        op_q;
   logic [2:0]        type_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [4:0]        rd_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       rsp_data_q;
   logic              rsp_wb_q;
   logic              err_misalign_q;
   logic              err_timeout_q;

   logic              accept;
   logic              misalign;
   logic              is_mem_op;
   logic              timeout_hit;
   logic              in_bus;
   logic              is_store;
   logic [31:0]       st_wdata;
   logic [3:0]        st_be;
   logic [31:0]       ld_data;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:ADDR_W];

   assign misalign  = is_misaligned(req_type, req_addr[1:0]);
   assign is_mem_op = (req_op == OP_LOAD) || (req_op == OP_STORE);
   // Ack in the same cycle as the last count wins over the timeout.
   assign timeout_hit = (TIMEOUT != 0) && !mem_ack && (cnt_q == CNT_LAST);

   lsu_align u_align (
      .ty       (type_q),
      .lane     (addr_q[1:0]),
      .wdata    (wdata_q),
      .rdata    (mem_rdata),
      .st_wdata (st_wdata),
      .st_be    (st_be),
      .ld_data  (ld_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      req_ready = 1'b0;
      mem_req   = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = !halt;
            if (req_valid && !halt) begin
               accept = 1'b1;
               // Misalignment takes priority over a no-op; neither touches the bus.
               state_d = (misalign || !is_mem_op) ? ST_RESP : ST_BUS;
            end
         end
         ST_BUS: begin
            mem_req = 1'b1;
            if (mem_ack || timeout_hit) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (!halt) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q           <= '0;
         type_q         <= '0;
         addr_q         <= '0;
         wdata_q        <= '0;
         rd_q           <= '0;
         cnt_q          <= '0;
         rsp_data_q     <= '0;
         rsp_wb_q       <= 1'b0;
         err_misalign_q <= 1'b0;
         err_timeout_q  <= 1'b0;
      end else begin
         if (accept) begin
            op_q       <= req_op;
            type_q     <= req_type;
            addr_q     <= req_addr[ADDR_W-1:0];
            wdata_q    <= req_wdata;
            rd_q       <= req_rd;
            cnt_q      <= '0;
            rsp_wb_q   <= 1'b0;
            rsp_data_q <= '0;
            if (misalign) begin
               err_misalign_q <= 1'b1;
            end
         end
         if (state_q == ST_BUS) begin
            if (mem_ack) begin
               rsp_wb_q   <= (op_q == OP_LOAD);
               rsp_data_q <= (op_q == OP_LOAD) ? ld_data : '0;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (timeout_hit) begin
                  err_timeout_q <= 1'b1;
               end
            end
         end
      end
   end

   // Bus outputs are only driven while a transaction is in flight.
   assign in_bus       = (state_q == ST_BUS);
   assign is_store     = (op_q == OP_STORE);
   assign mem_read_wrn = !(in_bus && is_store);
   assign mem_addr     = in_bus ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign mem_wdata    = (in_bus && is_store) ? st_wdata : '0;
   assign mem_be       = in_bus ? (is_store ? st_be : 4'b1111) : 4'b0000;

   assign rsp_wb       = (state_q == ST_RESP) && rsp_wb_q;
   assign rsp_rd       = rd_q;
   assign rsp_data     = rsp_data_q;
   assign stall        = (state_q != ST_IDLE) || (req_valid && !req_ready);
   assign err_misalign = err_misalign_q;
   assign err_timeout  = err_timeout_q;

endmodule
